// File: rtl/four_mult_feeder.sv
// four_mult_feeder: collects four serial operand words for a four-operand
// multiplier, runs the multiplier valid/done/ack handshake, then returns the
// 4*SIZE-bit product as four SIZE-bit words, least-significant word first.
// One product is in flight at a time.
// Optional feature: define FEEDER_TIMEOUT_EN to enable the WAIT_DONE watchdog
// (sticky oError, zero result after TIMEOUT_CYCLES without iMult_Done).
module four_mult_feeder #(
    parameter int SIZE           = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [SIZE-1:0]   iIn_Data,
    input  logic              iIn_Valid,
    output logic              oIn_Ready,
    output logic [SIZE-1:0]   oMult_A,
    output logic [SIZE-1:0]   oMult_B,
    output logic [SIZE-1:0]   oMult_C,
    output logic [SIZE-1:0]   oMult_D,
    output logic              oMult_Valid,
    output logic              oMult_Ack,
    input  logic              iMult_Done,
    input  logic              iMult_Idle,
    input  logic [4*SIZE-1:0] iMult_Result,
    output logic [SIZE-1:0]   oOut_Data,
    output logic              oOut_Valid,
    input  logic              iOut_Ready,
    output logic              oOut_Last,
    output logic              oBusy,
    output logic              oError
);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_START,
        S_WAIT_DONE,
        S_ACK,
        S_DRAIN
    } state_t;

    state_t                r_state;
    logic [1:0]            r_idx;          // operand index in COLLECT, word index in DRAIN
    logic [SIZE-1:0]       r_a;
    logic [SIZE-1:0]       r_b;
    logic [SIZE-1:0]       r_c;
    logic [SIZE-1:0]       r_d;
    logic [4*SIZE-1:0]     r_result;
    logic                  r_in_ready;
    logic                  r_mult_valid;
    logic                  r_mult_ack;
    logic                  r_out_valid;
    logic                  w_timeout;
    logic [3:0][SIZE-1:0]  w_words;

`ifdef FEEDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_error;

    assign w_timeout = (r_state == S_WAIT_DONE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared before WAIT_DONE is entered, counts cycles without done, flags a sticky error.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_error <= 1'b0;
        end else if (r_state == S_START) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT_DONE) && !iMult_Done) begin
            if (w_timeout) begin
                r_error <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign oError = r_error;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign oError           = 1'b0;
`endif

    // Main control FSM: collect operands, handshake with the multiplier, drain the product.
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_COLLECT;
            r_idx        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_d          <= '0;
            r_result     <= '0;
            r_in_ready   <= 1'b1;
            r_mult_valid <= 1'b0;
            r_mult_ack   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (iIn_Valid && r_in_ready) begin
                        case (r_idx)
                            2'd0:    r_a <= iIn_Data;
                            2'd1:    r_b <= iIn_Data;
                            2'd2:    r_c <= iIn_Data;
                            default: r_d <= iIn_Data;
                        endcase
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (iMult_Idle) begin
                        r_mult_valid <= 1'b1;
                        r_state      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (iMult_Done) begin
                        r_result     <= iMult_Result;
                        r_mult_valid <= 1'b0;
                        r_mult_ack   <= 1'b1;
                        r_state      <= S_ACK;
                    end else if (w_timeout) begin
                        r_result     <= '0;
                        r_mult_valid <= 1'b0;
                        r_mult_ack   <= 1'b1;
                        r_state      <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (iMult_Idle) begin
                        r_mult_ack  <= 1'b0;
                        r_idx       <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (iOut_Ready) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_out_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_COLLECT;
                        end
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign w_words     = r_result;
    assign oOut_Data   = w_words[r_idx];
    assign oOut_Last   = r_out_valid && (r_idx == 2'd3);
    assign oOut_Valid  = r_out_valid;
    assign oIn_Ready   = r_in_ready;
    assign oMult_A     = r_a;
    assign oMult_B     = r_b;
    assign oMult_C     = r_c;
    assign oMult_D     = r_d;
    assign oMult_Valid = r_mult_valid;
    assign oMult_Ack   = r_mult_ack;
    assign oBusy       = (r_state != S_COLLECT);

endmodule

// File: tb/tb_four_mult_feeder.sv
// tb_four_mult_feeder: randomized self-checking bench for four_mult_feeder.
// A transaction-level model turns every group of four accepted words into the
// four expected product words; one compare process checks the DUT each cycle.
// Define FEEDER_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_four_mult_feeder;

    localparam int SIZE = 32;
    localparam int TOUT = 16;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic [SIZE-1:0]   iIn_Data;
    logic              iIn_Valid;
    logic              oIn_Ready;
    logic [SIZE-1:0]   oMult_A, oMult_B, oMult_C, oMult_D;
    logic              oMult_Valid;
    logic              oMult_Ack;
    logic              iMult_Done;
    logic              iMult_Idle;
    logic [4*SIZE-1:0] iMult_Result;
    logic [SIZE-1:0]   oOut_Data;
    logic              oOut_Valid;
    logic              iOut_Ready;
    logic              oOut_Last;
    logic              oBusy;
    logic              oError;

    four_mult_feeder #(.SIZE(SIZE), .TIMEOUT_CYCLES(TOUT)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iIn_Data    (iIn_Data),
        .iIn_Valid   (iIn_Valid),
        .oIn_Ready   (oIn_Ready),
        .oMult_A     (oMult_A),
        .oMult_B     (oMult_B),
        .oMult_C     (oMult_C),
        .oMult_D     (oMult_D),
        .oMult_Valid (oMult_Valid),
        .oMult_Ack   (oMult_Ack),
        .iMult_Done  (iMult_Done),
        .iMult_Idle  (iMult_Idle),
        .iMult_Result(iMult_Result),
        .oOut_Data   (oOut_Data),
        .oOut_Valid  (oOut_Valid),
        .iOut_Ready  (iOut_Ready),
        .oOut_Last   (oOut_Last),
        .oBusy       (oBusy),
        .oError      (oError)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [SIZE-1:0] acc_words[$];     // words of the set being collected
    logic [SIZE-1:0] exp_out[$];       // product words still owed downstream
    logic [SIZE-1:0] exp_ops[4];       // operands of the latest complete set
    logic [SIZE-1:0] rx_log[$];        // every word transferred downstream
    bit              exp_zero = 1'b0;  // next set is expected to time out

    // ---------------- stimulus knobs ----------------
    int unsigned rdy_mode   = 0;       // 0: always ready, 1: 1,0,0 pattern, 2: random
    int unsigned rdy_cnt    = 0;
    bit          m_hang     = 1'b0;    // multiplier never raises done
    bit          m_spurious = 1'b0;    // random done pulses while idle
    int unsigned m_block    = 0;       // cycles the multiplier reports not idle

    // Downstream ready generator.
    initial begin
        iOut_Ready = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            case (rdy_mode)
                0: iOut_Ready = 1'b1;
                1: begin
                    iOut_Ready = (rdy_cnt % 3 == 0);
                    rdy_cnt++;
                end
                default: iOut_Ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Behavioural multiplier: product after a random latency, done until ack, idle after a random delay.
    initial begin
        int unsigned  m_phase;
        int unsigned  m_cnt;
        logic [127:0] m_prod;
        iMult_Idle   = 1'b1;
        iMult_Done   = 1'b0;
        iMult_Result = '0;
        m_phase      = 0;
        m_cnt        = 0;
        m_prod       = '0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                m_phase    = 0;
                iMult_Idle = 1'b1;
                iMult_Done = 1'b0;
            end else begin
                case (m_phase)
                    0: begin
                        iMult_Done = 1'b0;
                        if (oMult_Valid && iMult_Idle) begin
                            m_prod = 128'(oMult_A) * 128'(oMult_B) * 128'(oMult_C) * 128'(oMult_D);
                            iMult_Idle = 1'b0;
                            m_cnt      = $urandom_range(0, 4);
                            m_phase    = 1;
                        end else if (m_block > 0) begin
                            iMult_Idle = 1'b0;
                            m_block--;
                        end else begin
                            iMult_Idle = 1'b1;
                            if (m_spurious && ($urandom_range(0, 3) == 0)) begin
                                iMult_Done   = 1'b1;
                                iMult_Result = {$urandom(), $urandom(), $urandom(), $urandom()};
                            end
                        end
                    end
                    1: begin
                        if (oMult_Ack) begin
                            m_cnt   = $urandom_range(0, 3);
                            m_phase = 3;
                        end else if (!m_hang) begin
                            if (m_cnt == 0) begin
                                iMult_Done   = 1'b1;
                                iMult_Result = m_prod;
                                m_phase      = 2;
                            end else begin
                                m_cnt--;
                            end
                        end
                    end
                    2: begin
                        if (oMult_Ack) begin
                            iMult_Done   = 1'b0;
                            iMult_Result = ~m_prod;
                            m_cnt        = $urandom_range(0, 3);
                            m_phase      = 3;
                        end
                    end
                    default: begin
                        if (m_cnt == 0) begin
                            iMult_Idle = 1'b1;
                            m_phase    = 0;
                        end else begin
                            m_cnt--;
                        end
                    end
                endcase
            end
        end
    end

    // Compare process: checks the DUT against the transaction model every cycle.
    always @(negedge Clock) begin
        if (!Reset) begin
            check("rst_in_ready", oIn_Ready, 1'b1);
            check("rst_busy", oBusy, 1'b0);
            check("rst_mult_valid", oMult_Valid, 1'b0);
            check("rst_mult_ack", oMult_Ack, 1'b0);
            check("rst_out_valid", oOut_Valid, 1'b0);
            check("rst_error", oError, 1'b0);
            acc_words.delete();
            exp_out.delete();
        end else begin
            check("in_ready", oIn_Ready, exp_out.size() == 0);
            check("busy", oBusy, exp_out.size() != 0);
            if (oMult_Valid) begin
                check("mult_valid_when_pending", exp_out.size() != 0, 1'b1);
                check("op_a", oMult_A, exp_ops[0]);
                check("op_b", oMult_B, exp_ops[1]);
                check("op_c", oMult_C, exp_ops[2]);
                check("op_d", oMult_D, exp_ops[3]);
            end
            if (exp_out.size() == 0) begin
                check("out_valid_idle", oOut_Valid, 1'b0);
            end else if (oOut_Valid) begin
                check("out_data", oOut_Data, exp_out[0]);
                check("out_last", oOut_Last, exp_out.size() == 1);
                if (iOut_Ready) begin
                    rx_log.push_back(oOut_Data);
                    void'(exp_out.pop_front());
                end
            end
`ifndef FEEDER_TIMEOUT_EN
            check("error_clear", oError, 1'b0);
`endif
            if (iIn_Valid && oIn_Ready) begin
                acc_words.push_back(iIn_Data);
                if (acc_words.size() == 4) begin
                    logic [127:0] p;
                    p = 128'(acc_words[0]) * 128'(acc_words[1]) * 128'(acc_words[2]) * 128'(acc_words[3]);
                    if (exp_zero) p = '0;
                    for (int k = 0; k < 4; k++) begin
                        exp_ops[k] = acc_words[k];
                        exp_out.push_back(p[k*SIZE +: SIZE]);
                    end
                    acc_words.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic send_word(input logic [SIZE-1:0] w);
        bit ok;
        ok        = 1'b0;
        iIn_Data  = w;
        iIn_Valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge Clock);
            if (oIn_Ready) ok = 1'b1;
            step();
        end
        iIn_Valid = 1'b0;
        check("in_accepted", ok, 1'b1);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 3000 && rx_log.size() < n; i++) step();
        check("rx_count_reached", rx_log.size() >= n, 1'b1);
    endtask

    // Returns at the negedge where oMult_Valid is first seen high.
    task automatic wait_mult_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge Clock);
            if (oMult_Valid) seen = 1'b1;
        end
        check("mult_valid_seen", seen, 1'b1);
    endtask

    task automatic check_rx(input string name, input logic [SIZE-1:0] w0, input logic [SIZE-1:0] w1,
                            input logic [SIZE-1:0] w2, input logic [SIZE-1:0] w3);
        logic [SIZE-1:0] got[4];
        for (int k = 0; k < 4; k++) got[k] = (rx_log.size() > k) ? rx_log[k] : 'x;
        check({name, "_w0"}, got[0], w0);
        check({name, "_w1"}, got[1], w1);
        check({name, "_w2"}, got[2], w2);
        check({name, "_w3"}, got[3], w3);
    endtask

    // Global bound on simulated time.
    initial begin
        #2000000;
        n_bad++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [SIZE-1:0] w5;
        iIn_Valid = 1'b0;
        iIn_Data  = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_mult_a", oMult_A, '0);
        check("rst_out_data", oOut_Data, '0);
        check("rst_out_last", oOut_Last, 1'b0);
        Reset = 1'b1;
        step();

        // Single product 2,3,4,5 with latency check.
        rx_log.delete();
        send_word(2); send_word(3); send_word(4); send_word(5);
        @(negedge Clock);
        check("t1_valid_not_yet", oMult_Valid, 1'b0);
        check("t1_busy", oBusy, 1'b1);
        step();
        @(negedge Clock);
        check("t1_valid_rise", oMult_Valid, 1'b1);
        check("t1_a", oMult_A, 32'd2);
        check("t1_b", oMult_B, 32'd3);
        check("t1_c", oMult_C, 32'd4);
        check("t1_d", oMult_D, 32'd5);
        step();
        wait_rx(4);
        check_rx("t1", 32'h78, 32'h0, 32'h0, 32'h0);
        @(negedge Clock);
        check("t1_back_ready", oIn_Ready, 1'b1);
        step();

        // Wide operands.
        rx_log.delete();
        repeat (4) send_word(32'hFFFF_FFFF);
        wait_rx(4);
        check_rx("wide", 32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0005, 32'hFFFF_FFFC);

        // Backpressure 1,0,0 pattern.
        rx_log.delete();
        rdy_cnt  = 0;
        rdy_mode = 1;
        repeat (4) send_word($urandom());
        wait_rx(4);
        repeat (12) step();
        check("bp_transfer_count", rx_log.size(), 4);
        rdy_mode = 0;

        // Input gaps and busy lockout: 5th word waits and becomes next operand A.
        rx_log.delete();
        for (int k = 0; k < 4; k++) begin
            send_word($urandom());
            repeat ($urandom_range(1, 3)) step();
        end
        w5 = 32'hCAFE_0005;
        send_word(w5);
        check("lockout_drained_first", rx_log.size(), 4);
        send_word(11); send_word(12); send_word(13);
        wait_mult_valid();
        check("lockout_next_a", oMult_A, w5);
        step();
        wait_rx(8);

        // Reset during WAIT_DONE.
        m_hang = 1'b1;
        repeat (4) send_word(9);
        wait_mult_valid();
        repeat (2) @(posedge Clock);
        #3;
        Reset = 1'b0;
        #1;
        check("arst_mult_valid", oMult_Valid, 1'b0);
        check("arst_in_ready", oIn_Ready, 1'b1);
        check("arst_busy", oBusy, 1'b0);
        check("arst_mult_a", oMult_A, '0);
        check("arst_mult_ack", oMult_Ack, 1'b0);
        check("arst_out_valid", oOut_Valid, 1'b0);
        step();
        step();
        Reset  = 1'b1;
        m_hang = 1'b0;
        step();
        rx_log.delete();
        send_word(1); send_word(1); send_word(1); send_word(7);
        wait_rx(4);
        check_rx("post_rst", 32'd7, 32'd0, 32'd0, 32'd0);

        // Randomized sets with stalls, blocked multiplier and spurious done pulses.
        m_spurious = 1'b1;
        for (int s = 0; s < 25; s++) begin
            rdy_mode = $urandom_range(0, 2);
            m_block  = $urandom_range(0, 3);
            for (int k = 0; k < 4; k++) begin
                send_word($urandom());
                repeat ($urandom_range(0, 2)) step();
            end
        end
        rdy_mode = 0;
        for (int i = 0; i < 500 && exp_out.size() != 0; i++) step();
        check("random_all_drained", exp_out.size(), 0);
        m_spurious = 1'b0;

`ifdef FEEDER_TIMEOUT_EN
        // Watchdog: done never comes.
        begin
            int n;
            rx_log.delete();
            m_hang   = 1'b1;
            exp_zero = 1'b1;
            repeat (4) send_word($urandom_range(1, 1000));
            exp_zero = 1'b0;
            check("to_error_before", oError, 1'b0);
            wait_mult_valid();
            n = 0;
            for (int i = 0; i < 200; i++) begin
                if (oError) break;
                if (oMult_Valid) n++;
                @(negedge Clock);
            end
            check("to_cycles", n, TOUT);
            check("to_error_set", oError, 1'b1);
            check("to_ack", oMult_Ack, 1'b1);
            check("to_valid_clear", oMult_Valid, 1'b0);
            step();
            m_hang = 1'b0;
            wait_rx(4);
            check_rx("to_zero", 32'd0, 32'd0, 32'd0, 32'd0);
            repeat (4) send_word(3);
            wait_rx(8);
            check("to_error_sticky", oError, 1'b1);
            Reset = 1'b0;
            #1;
            check("to_error_reset", oError, 1'b0);
            step();
            Reset = 1'b1;
            step();
        end
`endif

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/four_mult_feeder.md
Name: four_mult_feeder

Overview:
- Front-end stage placed directly upstream of the four-operand multiplier (A*B*C*D, 4*SIZE-bit product).
- Collects the four operands as a serial word stream and drives the multiplier's valid/done/acknowledge handshake.
- Captures the product and returns it downstream as four SIZE-bit words, least-significant word first, on a valid/ready stream.
- One product in flight at a time.

Parameters:
SIZE, 32, operand word width; product width is 4*SIZE.
TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_DONE; used only when FEEDER_TIMEOUT_EN is defined.

Ports:
Clock  input  1  single clock, rising edge.
Reset  input  1  asynchronous, active-low; all state clears while Reset=0.
iIn_Data  input  SIZE  operand word; arrives in order A, B, C, D.
iIn_Valid  input  1  iIn_Data valid.
oIn_Ready  output  1  feeder accepts a word; transfer happens when iIn_Valid & oIn_Ready.
oMult_A, oMult_B, oMult_C, oMult_D  output  SIZE each  registered operands to the multiplier.
oMult_Valid  output  1  to multiplier valid-data input.
oMult_Ack  output  1  to multiplier acknowledge input.
iMult_Done  input  1  multiplier done flag.
iMult_Idle  input  1  multiplier idle flag.
iMult_Result  input  4*SIZE  multiplier product.
oOut_Data  output  SIZE  result word.
oOut_Valid  output  1  oOut_Data valid.
iOut_Ready  input  1  downstream accepts; transfer happens when oOut_Valid & iOut_Ready.
oOut_Last  output  1  high with the 4th (most-significant) result word.
oBusy  output  1  high in every state except COLLECT.
oError  output  1  sticky timeout flag.

Behaviour:
- Reset values:
  - All outputs 0, except oIn_Ready=1.
  - State=COLLECT; 2-bit word index=0; result register=0.
- COLLECT:
  - oIn_Ready=1.
  - Each accepted word is written to A/B/C/D by index (0..3), then the index increments.
  - On the 4th accept, the index wraps to 0 and the FSM moves to START.
  - Idle cycles with iIn_Valid=0 hold the index.
- START:
  - oIn_Ready=0.
  - If iMult_Idle=1: set oMult_Valid=1, then go to WAIT_DONE.
  - Otherwise stay in START until iMult_Idle=1.
- WAIT_DONE:
  - oMult_Valid is held at 1 until iMult_Done=1 is sampled.
  - On that cycle, latch iMult_Result into the result register, clear oMult_Valid, go to ACK.
  - Latency from the 4th accept to oMult_Valid=1 is 1 cycle when the multiplier is idle.
- ACK:
  - oMult_Ack=1, held until iMult_Idle=1 is sampled.
  - Then oMult_Ack=0 and the FSM moves to DRAIN with word index=0.
- DRAIN:
  - oOut_Valid=1; oOut_Data = result[index*SIZE +: SIZE].
  - oOut_Last=1 when index=3.
  - On each transfer the index increments.
  - On the transfer with oOut_Last=1: oOut_Valid=0, go to COLLECT.
  - oOut_Data and oOut_Last are stable while oOut_Valid=1 and iOut_Ready=0.
- Operand registers hold their values from START until the next COLLECT write.
- Input is not accepted in any state other than COLLECT. There is no overlap between a new operand set and the current drain.
- iMult_Done=1 outside WAIT_DONE is ignored.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - The partial operand set is discarded.
  - Any in-progress result is lost.
- Arithmetic: none inside the feeder. The product is treated as an unsigned 4*SIZE-bit value, passed through unmodified.

Optional Feature:
FEEDER_TIMEOUT_EN
- Defined:
  - A cycle counter of width clog2(TIMEOUT_CYCLES+1) runs in WAIT_DONE and clears on entry.
  - When it reaches TIMEOUT_CYCLES without iMult_Done: set oError=1 (sticky until Reset), load the result register with all-zeros, go to ACK.
  - The normal drain then outputs four zero words.
- Not defined: no counter; oError is tied to 0; WAIT_DONE waits indefinitely.

Test Plan:
- Single product: words 2,3,4,5 with iOut_Ready=1 -> oMult_A..D = 2,3,4,5; oMult_Valid rises 1 cycle after the 4th accept; output words 0x78, 0, 0, 0; oOut_Last on the 4th word; back to COLLECT with oIn_Ready=1.
- Wide operands, SIZE=32: all four words 0xFFFFFFFF -> output LSW first 0x00000001, 0xFFFFFFFC, 0x00000005, 0xFFFFFFFC.
- Backpressure: iOut_Ready toggling 1,0,0,1,... -> every word is held stable while stalled; no word is dropped or duplicated; exactly 4 transfers occur.
- Input gaps and busy lockout: iIn_Valid pulsed with gaps, and a 5th word offered during WAIT_DONE -> oIn_Ready=0; the 5th word is not taken; it becomes operand A of the next set.
- Reset mid-operation: drive Reset=0 in WAIT_DONE after 2 cycles -> all outputs return to reset values asynchronously; the next operand set 1,1,1,7 yields output words 7, 0, 0, 0.
- FEEDER_TIMEOUT_EN with TIMEOUT_CYCLES=16 and iMult_Done tied 0 -> oError=1 at cycle 16 of WAIT_DONE; oMult_Ack is asserted; output is four zero words; oError stays 1 until Reset.
